// File: rtl/led_scan_7_seg.sv
// led_scan_7_seg: drives NUM_DIGITS common-anode 7-segment digits, one digit per slot.
// A per-frame shadow copy of the inputs keeps a frame consistent. The driver also does
// leading-zero blanking, per-digit blinking and an anode-off guard at the start of each slot.
// All pins are registered and follow slot/shadow state with one cycle of latency.
module led_scan_7_seg #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned LZ_BLANK     = 1,
    localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    input  logic                    en_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [IDX_W-1:0]        digit_idx_o,
    output logic                    frame_o
);

    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned FCNT_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;

    // Segment pattern {a,b,c,d,e,f,g}, active-low; non-BCD codes are dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Timebase state
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tick, wrap, load;

    // Blink state
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_q, phase_d;

    // Shadow copies of the display inputs
    logic [4*NUM_DIGITS-1:0] sh_digits_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;
    logic [NUM_DIGITS-1:0]   sh_blink_q;

    // Pin-side decode
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [3:0]            cur_val;
    logic                  blink_off;
    logic                  guard;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic [IDX_W-1:0]      idx_out_q;
    logic                  frame_q;

    // Slot counter and digit index; the first edge after reset only loads the shadow
    // and starts slot 0, so frame 0 spans a full NUM_DIGITS*SCAN_DIV cycles.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        wrap  = ~start_q & tick & (idx_q == IDX_LAST);
        load  = start_q | wrap;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!start_q) begin
            if (tick) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Blink phase toggles after BLINK_FRAMES completed frames.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Timebase, blink and shadow registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q     <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_blink_q  <= '0;
        end else begin
            start_q <= 1'b0;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            if (load) begin
                sh_digits_q <= digits_i;
                sh_dp_q     <= dp_i;
                sh_blink_q  <= blink_mask_i;
            end
        end
    end

    // Leading-zero mask: a digit is blank when it and every digit above it are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run & (sh_digits_q[4*k +: 4] == 4'd0);
            lz_blank[k] = zero_run & (LZ_BLANK != 0);
        end
    end

    // Next pin values for the digit in the current slot.
    always_comb begin
        cur_val   = sh_digits_q[4*int'(idx_q) +: 4];
        blink_off = phase_q & sh_blink_q[idx_q];
        seg_d     = bcd_to_seg(cur_val);
        if (lz_blank[idx_q] || blink_off) begin
            seg_d = SEG_BLANK;
        end
        // Blinking hides the decimal point as well; leading-zero blanking does not.
        dp_d  = blink_off ? 1'b1 : ~sh_dp_q[idx_q];
        guard = (32'(cnt_q) < GUARD_CYC);
        an_d  = '1;
        if (!guard && en_i) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // Pin registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= '1;
            idx_out_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            idx_out_q <= idx_q;
            frame_q   <= load;
        end
    end

    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign an_o        = an_q;
    assign digit_idx_o = idx_out_q;
    assign frame_o     = frame_q;

endmodule

// File: doc/led_scan_7_seg.md
Name: led_scan_7_seg

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits in the clock display.
- Takes packed BCD digits, decimal-point, blink and enable controls, and scans one digit at a time.
- Per-frame input snapshot prevents tearing; adds leading-zero blanking, blinking and an anti-ghosting guard interval.
- Sits between the timekeeping counters and the board display pins; replaces per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 50000, clk_i cycles per digit slot (>= 2).
- GUARD_CYC, 16, cycles at slot start with all anodes off (0 <= GUARD_CYC < SCAN_DIV).
- BLINK_FRAMES, 64, full frames per blink half-period (>= 1).
- LZ_BLANK, 1, 1 = blank leading zero digits; digit 0 is never blanked by this rule.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- digits_i  in  4*NUM_DIGITS  BCD digits; digit k = bits [4k+3:4k], k=0 least significant
- dp_i  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- blink_mask_i  in  NUM_DIGITS  1 = digit blinks
- en_i  in  1  0 = all anodes off; scanning and counters continue
- seg_o  out  7  segments {a,b,c,d,e,f,g}, MSB = a, active-low
- dp_o  out  1  decimal point, active-low
- an_o  out  NUM_DIGITS  digit anodes, active-low, an_o[k] drives digit k
- digit_idx_o  out  max(1,clog2(NUM_DIGITS))  index of digit in current slot
- frame_o  out  1  one-cycle pulse when the shadow registers load

Behaviour:
- Reset (async, immediate):
  - an_o all 1, seg_o 7'b1111111, dp_o 1, digit_idx_o 0, frame_o 0.
  - Slot counter, blink frame counter and blink phase = 0; shadow registers = 0.
- Load strobe: fires on the first clk_i edge after rst_i deasserts, and on every slot tick where the index wraps NUM_DIGITS-1 -> 0.
  - On load: digits_i, dp_i and blink_mask_i are copied into shadow registers, and frame_o = 1 for that cycle.
  - Input changes between loads are not displayed until the next load.
- Slot counter counts 0..SCAN_DIV-1, then wraps.
  - The tick is the wrap cycle.
  - On each tick, idx increments modulo NUM_DIGITS.
  - Frame period = NUM_DIGITS*SCAN_DIV cycles.
- Output registers:
  - seg_o, dp_o, an_o and digit_idx_o are registered and computed from shadow data for the current idx.
  - Latency: one cycle from idx/shadow change to pins.
- Guard interval: while slot count < GUARD_CYC, an_o = all 1; seg_o and dp_o already show the new digit.
- Anode drive: otherwise, an_o = ~(1<<idx) when en_i = 1, and all 1 when en_i = 0.
- Decode table (seg_o):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - 10..15 = 1111111
- Leading-zero blanking (LZ_BLANK = 1): digit k is blanked if its shadow value is 0 and every digit above k is also 0; digit 0 is exempt.
  - A blanked digit has seg_o = 1111111; dp_o still follows dp_i.
- Blink:
  - The frame counter increments on each wrap tick.
  - At BLINK_FRAMES it clears and toggles blink phase.
  - While phase = 1, any digit with its shadow blink bit set outputs seg_o = 1111111 and dp_o = 1.
- dp_o = ~shadow_dp[idx] unless blanked by blink.
- Simultaneous events: load and tick coincide by definition; the new shadow data applies to slot 0 of the new frame.
- No other input affects timing.

Test Plan:
- Reset: NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYC=2; hold rst_i -> an_o=1111, seg_o=1111111, dp_o=1, frame_o=0. Release -> frame_o pulses once at first edge, then every 32 cycles.
- Scan: digits_i=16'h1234, LZ_BLANK=0 -> slot0 seg 1001100 with an 1110 after the 2-cycle guard (1111 during guard), then slot1 seg 0000110 / an 1101, slot2 seg 0010010 / an 1011, slot3 seg 1001111 / an 0111; repeats every 32 cycles.
- Snapshot: change digits_i to 16'h5678 during slot1 -> slots 1..3 still show 3,2,1; 5678 appears only after the next frame_o.
- Leading zeros: digits_i=16'h0070, LZ_BLANK=1 -> digits 3,2 seg 1111111, digit1 0001111, digit0 0000001. digits_i=16'h0000 -> only digit0 lit, showing 0000001. Digit value 4'hA -> 1111111.
- Blink: BLINK_FRAMES=2, blink_mask_i=0001, dp_i=0001 -> digit0 shows with dp_o=0 in frames 0-1, is blank with dp_o=1 in frames 2-3, and alternates thereafter; other digits are unaffected. en_i=0 -> an_o=1111 while frame_o continues.
- Async reset mid-slot: assert rst_i between clock edges in slot2 -> outputs return to reset values without a clock edge. Release -> scan restarts at idx 0 with a fresh load.
